// File: rtl/lock_reply_tx_if.sv
// Event inputs and serial-line outputs of the lock reply transmitter.
// master = event source / line observer, slave = the transmitter.
interface lock_reply_tx_if;
    logic auth;
    logic deny;
    logic tx;
    logic busy;
    logic done;

    modport master (
        output auth,
        output deny,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  auth,
        input  deny,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/lock_reply_tx.sv
// Answers lock events on the UART TX pin with "OPEN\r\n" or "DENY\r\n" (8N1, LSB first).
// Events are latched into pending flags so none are lost while a message is in flight.
module lock_reply_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic            clk,
    input  logic            reset,
    lock_reply_tx_if.slave  bus_if
);

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned MSG_LEN  = 6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BYTE_LAST = 3'(MSG_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    typedef enum logic {
        MSG_OPEN,
        MSG_DENY
    } msg_e;

    // Message ROM: both messages share the trailing CR LF.
    function automatic logic [7:0] msg_byte(input msg_e sel, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0:    b = (sel == MSG_OPEN) ? 8'h4F : 8'h44;
            3'd1:    b = (sel == MSG_OPEN) ? 8'h50 : 8'h45;
            3'd2:    b = (sel == MSG_OPEN) ? 8'h45 : 8'h4E;
            3'd3:    b = (sel == MSG_OPEN) ? 8'h4E : 8'h59;
            3'd4:    b = 8'h0D;
            3'd5:    b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_e           state_q;
    msg_e             sel_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [2:0]       byte_q;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;

    logic             auth_q;
    logic             pend_open_q;
    logic             pend_deny_q;
    logic             pend_open_d;
    logic             pend_deny_d;

    logic             auth_rise;
    logic             launch;
    logic             bit_end;
    logic [7:0]       cur_byte;
    logic [2:0]       bit_nxt;

    assign auth_rise = bus_if.auth & ~auth_q;
    assign launch    = (state_q == S_IDLE) & (pend_open_q | pend_deny_q);
    assign bit_end   = (cnt_q == CNT_LAST);
    assign cur_byte  = msg_byte(sel_q, byte_q);
    assign bit_nxt   = bit_q + 3'd1;

    // New events win over the launch clear, so an event in the launch cycle is kept.
    always_comb begin
        pend_open_d = pend_open_q;
        pend_deny_d = pend_deny_q;
        if (launch) begin
            if (pend_open_q) begin
                pend_open_d = 1'b0;
            end else begin
                pend_deny_d = 1'b0;
            end
        end
        if (auth_rise) begin
            pend_open_d = 1'b1;
        end
        if (bus_if.deny) begin
            pend_deny_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            auth_q      <= 1'b0;
            pend_open_q <= 1'b0;
            pend_deny_q <= 1'b0;
        end else begin
            auth_q      <= bus_if.auth;
            pend_open_q <= pend_open_d;
            pend_deny_q <= pend_deny_d;
        end
    end

    // Framer FSM; outputs are loaded with the value belonging to the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= MSG_OPEN;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    cnt_q  <= '0;
                    if (launch) begin
                        sel_q   <= pend_open_q ? MSG_OPEN : MSG_DENY;
                        byte_q  <= '0;
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= S_DATA;
                        tx_q    <= cur_byte[0];
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_nxt;
                            tx_q  <= cur_byte[bit_nxt];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (byte_q < BYTE_LAST) begin
                            byte_q  <= byte_q + 3'd1;
                            state_q <= S_START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus_if.tx   = tx_q;
    assign bus_if.busy = busy_q;
    assign bus_if.done = done_q;

endmodule

// File: tb/tb_lock_reply_tx.sv
// Scoreboard bench for lock_reply_tx: stimulus pushes expected bytes, a UART monitor
// decodes the tx line and pops/compares them.
module tb_lock_reply_tx;

    localparam int unsigned CPB = 4;

    logic clk = 1'b0;
    logic reset;

    lock_reply_tx_if bus_if();

    lock_reply_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus_if.slave)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    int         exp_done = 0;
    int         rst_cnt  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_open();
        logic [7:0] m [6];
        m = '{8'h4F, 8'h50, 8'h45, 8'h4E, 8'h0D, 8'h0A};
        for (int i = 0; i < 6; i++) exp_q.push_back(m[i]);
    endtask

    task automatic push_deny();
        logic [7:0] m [6];
        m = '{8'h44, 8'h45, 8'h4E, 8'h59, 8'h0D, 8'h0A};
        for (int i = 0; i < 6; i++) exp_q.push_back(m[i]);
    endtask

    task automatic wait_done_cnt(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_wait", 32'(done_cnt >= target), 32'd1);
    endtask

    // Quiet period after a scenario: no further bytes, done pulses, or activity.
    task automatic settle(input int cycles);
        repeat (cycles) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("done_total", 32'(done_cnt), 32'(exp_done));
        check("idle_tx", 32'(bus_if.tx), 32'd1);
        check("idle_busy", 32'(bus_if.busy), 32'd0);
    endtask

    always @(posedge clk) if (reset) rst_cnt <= rst_cnt + 1;
    always @(negedge clk) if (bus_if.done === 1'b1) done_cnt <= done_cnt + 1;

    // UART monitor: detect start bit, sample each bit mid-cell, drop frames cut by reset.
    initial begin : uart_mon
        logic [7:0]  rx;
        logic [31:0] e;
        int          r0;
        forever begin
            @(negedge clk);
            if (bus_if.tx === 1'b0 && reset === 1'b0) begin
                r0 = rst_cnt;
                rx = '0;
                repeat (CPB + 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    rx[i] = bus_if.tx;
                    if (i < 7) repeat (CPB) @(negedge clk);
                end
                repeat (CPB) @(negedge clk);
                if (rst_cnt == r0) begin
                    check("stop_bit", 32'(bus_if.tx), 32'd1);
                    e = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
                    check("rx_byte", 32'(rx), e);
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int busy_lo;
        int bad;
        bus_if.auth = 1'b0;
        bus_if.deny = 1'b0;
        reset       = 1'b1;

        // 1: reset then idle
        repeat (10) @(negedge clk);
        check("rst_tx", 32'(bus_if.tx), 32'd1);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_done", 32'(bus_if.done), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_tx", 32'(bus_if.tx), 32'd1);
            check("idle_busy", 32'(bus_if.busy), 32'd0);
            check("idle_done", 32'(bus_if.done), 32'd0);
        end

        // 2: auth rising edge, exact timing
        bus_if.auth = 1'b1;
        push_open();
        exp_done++;
        @(negedge clk);
        check("k_tx", 32'(bus_if.tx), 32'd1);
        check("k_busy", 32'(bus_if.busy), 32'd0);
        @(negedge clk);
        check("k1_tx", 32'(bus_if.tx), 32'd0);
        check("k1_busy", 32'(bus_if.busy), 32'd1);
        busy_lo = 0;
        repeat (239) begin
            @(negedge clk);
            if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0) busy_lo++;
        end
        check("busy_window", 32'(busy_lo), 32'd0);
        @(negedge clk);
        check("k241_busy", 32'(bus_if.busy), 32'd0);
        check("k241_done", 32'(bus_if.done), 32'd1);
        @(negedge clk);
        check("done_width", 32'(bus_if.done), 32'd0);
        settle(40);
        bus_if.auth = 1'b0;
        repeat (3) @(negedge clk);

        // 3: single deny strobe
        bus_if.deny = 1'b1;
        push_deny();
        exp_done++;
        @(negedge clk);
        bus_if.deny = 1'b0;
        wait_done_cnt(exp_done, 400);
        settle(40);

        // 4: auth and deny together -> OPEN, one idle cycle, DENY
        bus_if.auth = 1'b1;
        bus_if.deny = 1'b1;
        push_open();
        push_deny();
        exp_done += 2;
        @(negedge clk);
        bus_if.deny = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) break;
        end
        check("gap_done_seen", 32'(bus_if.done), 32'd1);
        check("gap_tx", 32'(bus_if.tx), 32'd1);
        check("gap_busy", 32'(bus_if.busy), 32'd0);
        @(negedge clk);
        check("second_start_tx", 32'(bus_if.tx), 32'd0);
        check("second_start_busy", 32'(bus_if.busy), 32'd1);
        wait_done_cnt(exp_done, 400);
        settle(40);
        bus_if.auth = 1'b0;
        repeat (3) @(negedge clk);

        // 5: three deny strobes during OPEN merge into one DENY
        bus_if.auth = 1'b1;
        push_open();
        push_deny();
        exp_done += 2;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus_if.deny = 1'b1;
            @(negedge clk);
            bus_if.deny = 1'b0;
            repeat (29) @(negedge clk);
        end
        wait_done_cnt(exp_done, 800);
        settle(300);
        bus_if.auth = 1'b0;
        repeat (3) @(negedge clk);

        // 6: reset at message cycle 50 abandons the message (first byte already sent)
        bus_if.auth = 1'b1;
        exp_q.push_back(8'h4F);
        @(negedge clk);
        @(negedge clk);
        check("r6_start_tx", 32'(bus_if.tx), 32'd0);
        repeat (19) @(negedge clk);
        bus_if.auth = 1'b0;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("r6_tx", 32'(bus_if.tx), 32'd1);
        check("r6_busy", 32'(bus_if.busy), 32'd0);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus_if.tx !== 1'b1 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) bad++;
        end
        check("r6_quiet", 32'(bad), 32'd0);
        check("r6_done_total", 32'(done_cnt), 32'(exp_done));
        check("r6_queue", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
